// File: rtl/mips_if_pkg.sv
// ============================================================================
//  Module   : mips_if_pkg
//  Purpose  : Shared constants, IF/ID payload type and alignment helper for
//             the MIPS32 instruction-fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_if_pkg;

    localparam int WORD_W = 32;

    // Default reset PC and bubble word (sll $0,$0,0 encodes as all zeros)
    localparam logic [WORD_W-1:0] c_reset_pc  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] c_nop_instr = 32'h0000_0000;

    // Payload carried from IF into ID
    typedef struct packed {
        logic [WORD_W-1:0] pc_plus_4;
        logic [WORD_W-1:0] instr;
        logic              valid;
    } if_id_t;

    // Force a byte address onto a word boundary
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register with hold (stall) and bubble (flush)
//             controls. Hold has priority over bubble.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_if_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = c_nop_instr
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic [WORD_W-1:0] i_pc_plus_4,
    input  logic [WORD_W-1:0] i_instr,
    output if_id_t            o_if_id
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Next IF/ID contents: hold, inject a bubble, or capture the fetched word
    always_comb begin
        if_id_d = if_id_q;
        if (!i_hold) begin
            if_id_d.pc_plus_4 = i_pc_plus_4;
            if (i_bubble) begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
            end else begin
                if_id_d.instr = i_instr;
                if_id_d.valid = 1'b1;
            end
        end
    end

    // IF/ID register with asynchronous active-low reset to an empty bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.pc_plus_4 <= '0;
            if_id_q.instr     <= NOP_INSTR;
            if_id_q.valid     <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign o_if_id = if_id_q;

endmodule

`default_nettype wire

// File: rtl/if_pc_fetch.sv
// ============================================================================
//  Module   : if_pc_fetch
//  Purpose  : IF-stage program counter, next-PC select with a one-entry
//             pending-redirect buffer (so a redirect arriving during a stall
//             is not lost), and the IF/ID pipeline register.
//  Config   : IF_ALIGN_CHECK_EN - when defined, Misaligned_Err is a sticky
//             flag set by any accepted redirect whose target is not word
//             aligned; when undefined the flag is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_pc_fetch
    import mips_if_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = c_reset_pc,
    parameter logic [WORD_W-1:0] NOP_INSTR = c_nop_instr
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall_IF,
    input  logic              Branch_Taken_ID,
    input  logic [WORD_W-1:0] Branch_Dest_ID,
    input  logic [WORD_W-1:0] Instruction_IF,
    output logic [WORD_W-1:0] PC_IF,
    output logic [WORD_W-1:0] PC_Plus_4_ID,
    output logic [WORD_W-1:0] Instruction_ID,
    output logic              Valid_ID,
    output logic              Misaligned_Err
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0] pend_dest_q, pend_dest_d;

    logic [WORD_W-1:0] w_pc_plus_4;
    logic [WORD_W-1:0] w_live_dest;
    logic              w_redirect;
    if_id_t            w_if_id;

    assign w_pc_plus_4 = pc_q + 32'd4;
    assign w_live_dest = align_word(Branch_Dest_ID);

    // Next-PC select and pending-redirect bookkeeping. A live redirect beats a
    // pending one; any unstalled edge consumes (clears) the pending entry.
    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_dest_d  = pend_dest_q;
        w_redirect   = 1'b0;
        if (Stall_IF) begin
            if (Branch_Taken_ID) begin
                pend_valid_d = 1'b1;
                pend_dest_d  = w_live_dest;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (Branch_Taken_ID) begin
                pc_d       = w_live_dest;
                w_redirect = 1'b1;
            end else if (pend_valid_q) begin
                pc_d       = pend_dest_q;
                w_redirect = 1'b1;
            end else begin
                pc_d       = w_pc_plus_4;
            end
        end
    end

    // PC and pending-redirect registers; reset discards any pending redirect
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_dest_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_dest_q  <= pend_dest_d;
        end
    end

    // The wrong-path word fetched alongside a redirect is squashed (no delay slot)
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .i_hold      (Stall_IF),
        .i_bubble    (w_redirect),
        .i_pc_plus_4 (w_pc_plus_4),
        .i_instr     (Instruction_IF),
        .o_if_id     (w_if_id)
    );

    assign PC_IF          = pc_q;
    assign PC_Plus_4_ID   = w_if_id.pc_plus_4;
    assign Instruction_ID = w_if_id.instr;
    assign Valid_ID       = w_if_id.valid;

`ifdef IF_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    // Any accepted redirect (live or captured into pending) with a
    // non-word-aligned target sets the flag; only reset clears it.
    always_comb begin
        misaligned_d = misaligned_q;
        if (Branch_Taken_ID && (Branch_Dest_ID[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
        end
    end

    // Sticky misalignment flag register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign Misaligned_Err = misaligned_q;
`else
    // Target low bits are simply dropped by the word alignment
    logic w_unused_dest_bits;
    assign w_unused_dest_bits = ^Branch_Dest_ID[1:0];
    assign Misaligned_Err     = 1'b0;
`endif

endmodule

`default_nettype wire
